mac_operand_feeder: RTL

MAC_OPERAND_FEEDER -- requirements
Module: mac_operand_feeder

---
 rtl/mac_operand_feeder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mac_operand_feeder.sv
`default_nettype none
// ============================================================================
// mac_operand_feeder : dual operand FIFOs streaming pairs into an external MAC
// Revision: 1.0
// ============================================================================
module mac_operand_feeder #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    a_wr_en,
   input  logic [DATA_WIDTH-1:0]   a_wr_data,
   input  logic                    b_wr_en,
   input  logic [DATA_WIDTH-1:0]   b_wr_data,
   output logic                    a_full,
   output logic                    a_empty,
   output logic                    b_full,
   output logic                    b_empty,
   input  logic                    start,
   output logic                    busy,
   output logic                    err,
   output logic                    mac_en,
   output logic                    mac_clr,
   output logic [DATA_WIDTH-1:0]   mac_a,
   output logic [DATA_WIDTH-1:0]   mac_b,
   input  logic [3*DATA_WIDTH-1:0] mac_cout,
   output logic [3*DATA_WIDTH-1:0] result,
   output logic                    done
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      STREAM = 3'd2,
      DRAIN  = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] a_mem [DEPTH];
   logic [DATA_WIDTH-1:0] b_mem [DEPTH];
   logic [AW-1:0]         a_wr_ptr;
   logic [AW-1:0]         a_rd_ptr;
   logic [AW-1:0]         b_wr_ptr;
   logic [AW-1:0]         b_rd_ptr;
   logic [CW-1:0]         a_count;
   logic [CW-1:0]         b_count;
   logic [CW-1:0]         len_left;
   logic                  a_push;
   logic                  b_push;
   logic                  pop;

   assign a_full  = (a_count == CW'(DEPTH));
   assign b_full  = (b_count == CW'(DEPTH));
   assign a_empty = (a_count == '0);
   assign b_empty = (b_count == '0);
   assign a_push  = a_wr_en && !a_full && !busy;
   assign b_push  = b_wr_en && !b_full && !busy;
   // Popping coincides with loading the operand registers from the FIFO heads
   assign pop     = (state == CLEAR) || ((state == STREAM) && (len_left != '0));

   always_ff @(posedge clk) begin
      if (a_push) a_mem[a_wr_ptr] <= a_wr_data;
      if (b_push) b_mem[b_wr_ptr] <= b_wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_wr_ptr <= '0;
         a_rd_ptr <= '0;
         b_wr_ptr <= '0;
         b_rd_ptr <= '0;
         a_count  <= '0;
         b_count  <= '0;
      end else begin
         if (a_push) a_wr_ptr <= a_wr_ptr + AW'(1);
         if (b_push) b_wr_ptr <= b_wr_ptr + AW'(1);
         if (pop) begin
            a_rd_ptr <= a_rd_ptr + AW'(1);
            b_rd_ptr <= b_rd_ptr + AW'(1);
         end
         case ({a_push, pop})
            2'b10:   a_count <= a_count + CW'(1);
            2'b01:   a_count <= a_count - CW'(1);
            default: a_count <= a_count;
         endcase
         case ({b_push, pop})
            2'b10:   b_count <= b_count + CW'(1);
            2'b01:   b_count <= b_count - CW'(1);
            default: b_count <= b_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         err      <= 1'b0;
         done     <= 1'b0;
         mac_en   <= 1'b0;
         mac_clr  <= 1'b0;
         mac_a    <= '0;
         mac_b    <= '0;
         result   <= '0;
         len_left <= '0;
      end else begin
         err     <= 1'b0;
         done    <= 1'b0;
         mac_clr <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if ((a_count == b_count) && (a_count != '0)) begin
                     len_left <= a_count;
                     mac_clr  <= 1'b1;
                     busy     <= 1'b1;
                     state    <= CLEAR;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            CLEAR: begin
               mac_en   <= 1'b1;
               mac_a    <= a_mem[a_rd_ptr];
               mac_b    <= b_mem[b_rd_ptr];
               len_left <= len_left - CW'(1);
               state    <= STREAM;
            end
            STREAM: begin
               if (len_left != '0) begin
                  mac_a    <= a_mem[a_rd_ptr];
                  mac_b    <= b_mem[b_rd_ptr];
                  len_left <= len_left - CW'(1);
               end else begin
                  mac_en <= 1'b0;
                  state  <= DRAIN;
               end
            end
            DRAIN: begin
               // Last product has landed in the accumulator by now
               result <= mac_cout;
               done   <= 1'b1;
               state  <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy   <= 1'b0;
               mac_en <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
